// File: rtl/sv_mmul_r2l_pkg.sv
// Shared types and sizing for the LSB-first modular multiplier.
// Optional build macro used by the top: SV_MMUL_EARLY_EXIT_EN.
package sv_mmul_r2l_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // One extra bit so the counter can reach DATA_WIDTH without wrapping.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/sv_ma.sv
// Modular adder: s = (a + b) mod q for a, b < q.
// Related build macro (used by the top only): SV_MMUL_EARLY_EXIT_EN.
module sv_ma #(
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0] q_i,
  output logic [DATA_WIDTH-1:0] s_o
);

  logic [DATA_WIDTH:0] sum;

  // Sum is one bit wider so the carry survives the compare against q.
  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i};
    if (sum >= {1'b0, q_i}) begin
      s_o = DATA_WIDTH'(sum - {1'b0, q_i});
    end else begin
      s_o = sum[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/sv_mmul_r2l.sv
// Right-to-left (LSB-first) interleaved modular multiplier: z = x*y mod q.
// Define SV_MMUL_EARLY_EXIT_EN to stop once the remaining multiplier bits are zero.
module sv_mmul_r2l
  import sv_mmul_r2l_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] q_i,
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [DATA_WIDTH-1:0] y_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] z_o
);

  localparam int unsigned CW = cnt_width(DATA_WIDTH);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] q;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_sum;
  logic [DATA_WIDTH-1:0] a_dbl;
  logic [DATA_WIDTH-1:0] acc_next;
  logic                  last;

  sv_ma #(.DATA_WIDTH(DATA_WIDTH)) u_ma_acc (
    .a_i (acc),
    .b_i (a),
    .q_i (q),
    .s_o (acc_sum)
  );

  sv_ma #(.DATA_WIDTH(DATA_WIDTH)) u_ma_dbl (
    .a_i (a),
    .b_i (a),
    .q_i (q),
    .s_o (a_dbl)
  );

  always_comb begin
    acc_next = b[0] ? acc_sum : acc;
    last     = (cnt == CW'(DATA_WIDTH - 1));
`ifdef SV_MMUL_EARLY_EXIT_EN
    last     = last | ((b >> 1) == '0);
`endif
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      z_o    <= '0;
      q      <= '0;
      a      <= '0;
      b      <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          // A start coinciding with the done pulse waits one cycle.
          if (start_i && !done_o) begin
            q      <= q_i;
            a      <= x_i;
            b      <= y_i;
            acc    <= '0;
            cnt    <= '0;
            busy_o <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          a   <= a_dbl;
          b   <= b >> 1;
          cnt <= cnt + 1'b1;
          if (last) begin
            z_o    <= acc_next;
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sv_mmul_r2l.sv
// Directed bench for sv_mmul_r2l (DATA_WIDTH=8, q=251) with a behavioural reference model.
module tb_sv_mmul_r2l;

  localparam int unsigned W = 8;
`ifdef SV_MMUL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         arst_n_i = 1'b0;
  logic         start_i = 1'b0;
  logic [W-1:0] q_i = 8'd251;
  logic [W-1:0] x_i = '0;
  logic [W-1:0] y_i = '0;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] z_o;

  int checks = 0;
  int failures = 0;

  sv_mmul_r2l #(.DATA_WIDTH(W)) dut (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .start_i  (start_i),
    .q_i      (q_i),
    .x_i      (x_i),
    .y_i      (y_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .z_o      (z_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Latency: full width, or (early exit) position of the top set bit of y, minimum 1.
  function automatic int lat_of(input logic [W-1:0] y);
    int l = 1;
    for (int i = 0; i < W; i++) if (y[i]) l = i + 1;
    return EE ? l : W;
  endfunction

  // Reference model: product by plain arithmetic, completion after lat_of(y) cycles.
  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  int   m_z = 0;
  int   m_pend = 0;
  int   m_rem = 0;

  always @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      m_busy = 1'b0; m_done = 1'b0; m_z = 0; m_rem = 0;
    end else if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 1'b0; m_done = 1'b1; m_z = m_pend;
      end
    end else begin
      if (start_i && !m_done) begin
        m_busy = 1'b1;
        m_rem  = lat_of(y_i);
        m_pend = (int'(x_i) * int'(y_i)) % int'(q_i);
      end
      m_done = 1'b0;
    end
  end

  always @(negedge clk_i) begin
    check("busy_o", int'(busy_o), int'(m_busy));
    check("done_o", int'(done_o), int'(m_done));
    check("z_o", int'(z_o), m_z);
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input int ez, input int el, input string tag);
    int n;
    bit seen;
    @(negedge clk_i);
    q_i = 8'd251; x_i = x; y_i = y; start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    x_i = 8'($urandom); y_i = 8'($urandom); q_i = 8'd3;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk_i);
      #1;
      n++;
      if (done_o) seen = 1'b1;
    end
    check({tag, "_latency"}, n, el);
    check({tag, "_z"}, int'(z_o), ez);
    q_i = 8'd251;
    @(negedge clk_i);
  endtask

  initial begin
    int first_done;
    int second_done;
    int ndone;

    repeat (3) @(negedge clk_i);
    check("reset_busy", int'(busy_o), 0);
    check("reset_done", int'(done_o), 0);
    check("reset_z", int'(z_o), 0);
    arst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);

    run_op(8'd7,   8'd9,   63, EE ? 4 : 8, "x7y9");
    run_op(8'd250, 8'd250, 1,  8,          "x250y250");
    run_op(8'd200, 8'd3,   98, EE ? 2 : 8, "x200y3");
    run_op(8'd0,   8'd255, 0,  8,          "x0y255");
    run_op(8'd5,   8'd0,   0,  EE ? 1 : 8, "x5y0");
    run_op(8'd7,   8'd1,   7,  EE ? 1 : 8, "x7y1");
    run_op(8'd7,   8'd128, 143, 8,         "x7y128");

    // Start held high: done pulses on edges L and 2L+2 counting the start edge as 0.
    @(negedge clk_i);
    x_i = 8'd7; y_i = 8'd9; start_i = 1'b1;
    first_done = -1; second_done = -1; ndone = 0;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk_i);
      #1;
      if (e == 11) start_i = 1'b0;
      if (done_o) begin
        ndone++;
        if (first_done < 0) first_done = e;
        else if (second_done < 0) second_done = e;
      end
    end
    check("held_first_done", first_done, EE ? 4 : 8);
    check("held_second_done", second_done, EE ? 10 : 18);
    check("held_done_count", ndone, 2);
    check("held_z", int'(z_o), 63);

    // Reset pulse during the fourth RUN cycle aborts the operation.
    @(negedge clk_i);
    x_i = 8'd7; y_i = 8'd9; start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;
    arst_n_i = 1'b0;
    #1;
    check("abort_busy", int'(busy_o), 0);
    check("abort_done", int'(done_o), 0);
    check("abort_z", int'(z_o), 0);
    @(negedge clk_i);
    arst_n_i = 1'b1;
    ndone = 0;
    for (int e = 0; e < 15; e++) begin
      @(negedge clk_i);
      if (done_o) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_z_after", int'(z_o), 0);
    run_op(8'd7, 8'd9, 63, EE ? 4 : 8, "after_abort");

    repeat (2) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
